// File: rtl/stream_config_regs_if.sv
// Shared types plus the config write port and the stream-config ready/valid port.
package stream_config_pkg;
    localparam int AXI_ADDR_BITS  = 32;
    localparam int AXIL_DATA_BITS = 32;
    typedef logic [3:0] type_t;
endpackage

interface config_i;
    import stream_config_pkg::*;
    logic [AXI_ADDR_BITS-1:0]  addr;
    logic [AXIL_DATA_BITS-1:0] data;
    logic                      valid;
    modport m (output addr, data, valid);
    modport s (input addr, data, valid);
endinterface

interface stream_config_i #(
    parameter int NUM_SELECT = 4
);
    import stream_config_pkg::*;
    localparam int SEL_W = (NUM_SELECT > 1) ? $clog2(NUM_SELECT) : 1;
    logic [SEL_W-1:0] select_data;
    logic             select_valid;
    logic             select_ready;
    type_t            data_type_data;
    logic             data_type_valid;
    logic             data_type_ready;
    modport m (output select_data, select_valid, data_type_data, data_type_valid,
               input  select_ready, data_type_ready);
    modport s (input  select_data, select_valid, data_type_data, data_type_valid,
               output select_ready, data_type_ready);
endinterface

// File: rtl/stream_config_regs.sv
// Decodes config writes into select / data_type FIFOs exposed as ready/valid channels,
// with saturating drop and range-error counters.
module stream_config_fifo #(
    parameter int W     = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     ready,
    output logic                     valid,
    output logic [W-1:0]             head,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     drop
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem_q [DEPTH];
    logic         full, pop, push_ok;

    always_comb begin
        level    = wr_ptr_q - rd_ptr_q;
        valid    = (level != '0);
        full     = (level == (AW+1)'(DEPTH));
        head     = mem_q[rd_ptr_q[AW-1:0]];
        pop      = valid & ready;
        // A pop on the same edge frees the slot, so a full queue still accepts.
        push_ok  = push & (~full | pop);
        drop     = push & full & ~pop;
        wr_ptr_d = wr_ptr_q + (AW+1)'(push_ok);
        rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end
endmodule

module stream_config_regs
    import stream_config_pkg::*;
#(
    parameter int          NUM_SELECT  = 4,
    parameter int unsigned ADDR_BASE   = 0,
    parameter int          QUEUE_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    config_i.s                           cfg,
    stream_config_i.m                    out,
    output logic [15:0]                  drop_cnt,
    output logic [15:0]                  err_cnt,
    output logic [$clog2(QUEUE_DEPTH):0] select_level,
    output logic [$clog2(QUEUE_DEPTH):0] type_level
);
    localparam int SEL_W = (NUM_SELECT > 1) ? $clog2(NUM_SELECT) : 1;
    localparam int TW    = $bits(type_t);
    localparam logic [AXI_ADDR_BITS-1:0] A_SEL = AXI_ADDR_BITS'(ADDR_BASE);
    localparam logic [AXI_ADDR_BITS-1:0] A_TYP = AXI_ADDR_BITS'(ADDR_BASE + 8);
    localparam logic [AXI_ADDR_BITS-1:0] A_CLR = AXI_ADDR_BITS'(ADDR_BASE + 16);

    logic        sel_hit, typ_hit, clr_hit, sel_in_range;
    logic        sel_push, sel_err, sel_drop, typ_drop;
    logic [SEL_W-1:0] sel_head;
    logic [TW-1:0]    typ_head;
    logic [15:0] drop_cnt_q, drop_cnt_d, err_cnt_q, err_cnt_d;

    always_comb begin
        sel_hit      = cfg.valid & (cfg.addr == A_SEL);
        typ_hit      = cfg.valid & (cfg.addr == A_TYP);
        clr_hit      = cfg.valid & (cfg.addr == A_CLR);
        // Range check uses the full data word so upper garbage cannot alias a valid select.
        sel_in_range = (cfg.data < AXIL_DATA_BITS'(NUM_SELECT));
        sel_push     = sel_hit & sel_in_range;
        sel_err      = sel_hit & ~sel_in_range;
    end

    stream_config_fifo #(.W(SEL_W), .DEPTH(QUEUE_DEPTH)) u_sel_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (sel_push),
        .push_data (cfg.data[SEL_W-1:0]),
        .ready     (out.select_ready),
        .valid     (out.select_valid),
        .head      (sel_head),
        .level     (select_level),
        .drop      (sel_drop)
    );

    stream_config_fifo #(.W(TW), .DEPTH(QUEUE_DEPTH)) u_typ_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (typ_hit),
        .push_data (cfg.data[TW-1:0]),
        .ready     (out.data_type_ready),
        .valid     (out.data_type_valid),
        .head      (typ_head),
        .level     (type_level),
        .drop      (typ_drop)
    );

    always_comb begin
        out.select_data    = sel_head;
        out.data_type_data = type_t'(typ_head);
        drop_cnt_d = drop_cnt_q;
        err_cnt_d  = err_cnt_q;
        if (clr_hit) begin
            drop_cnt_d = '0;
            err_cnt_d  = '0;
        end else begin
            if ((sel_drop | typ_drop) && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
            if (sel_err && err_cnt_q != 16'hFFFF)                 err_cnt_d  = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
    assign err_cnt  = err_cnt_q;
endmodule
